// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave receiver, one MOSI bit per clk while cs_n is low.
// Back-to-back words are packed into a first-word-fall-through FIFO, and a
// parallel transmit word is shifted out on MISO in the same bit order.
module spi_frame_rx #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cs_n,
  input  logic                              mosi,
  output logic                              miso,
  output logic                              miso_oe,
  input  logic [WORD_W-1:0]                 tx_data,
  input  logic                              rd_en,
  output logic [WORD_W-1:0]                 rd_data,
  output logic                              rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              frame_err,
  input  logic                              clr_flags
);

  localparam int unsigned CNT_W  = $clog2(WORD_W);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                sample;
  logic                last_bit;
  logic                abort;

  // Only WORD_W-1 bits of a partial word ever need storing; the last bit
  // arrives on the push edge itself.
  logic [WORD_W-2:0]   part_q;
  logic [WORD_W-1:0]   word_asm;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   tx_shift;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_ptr_p1;
  logic                full;
  logic                empty;
  logic                pop_ok;
  logic                push_ok;
  logic                ovf_evt;
  logic [FCNT_W-1:0]   count_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    last_bit = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n) begin
          sample  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_n) begin
          state_d = IDLE;
          abort   = (bit_cnt != '0);
        end else begin
          sample = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    last_bit = sample && (bit_cnt == CNT_W'(WORD_W - 1));
  end

  // Word assembly: incoming bit joined with the stored partial word
  always_comb begin
    if (LSB_FIRST) begin
      word_asm = {mosi, part_q};
    end else begin
      word_asm = {part_q, mosi};
    end
  end

  // Receive shift, bit counter and transmit shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      part_q   <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
    end else if (cs_n) begin
      bit_cnt  <= '0;
      tx_shift <= tx_data;
    end else if (sample) begin
      if (LSB_FIRST) begin
        part_q <= word_asm[WORD_W-1:1];
      end else begin
        part_q <= word_asm[WORD_W-2:0];
      end
      if (last_bit) begin
        bit_cnt  <= '0;
        tx_shift <= tx_data;
      end else begin
        bit_cnt  <= bit_cnt + CNT_W'(1);
        tx_shift <= LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
      end
    end
  end

  // MISO driven straight from the transmit shift register
  always_comb begin
    miso_oe = !cs_n;
    if (cs_n) begin
      miso = 1'b0;
    end else if (LSB_FIRST) begin
      miso = tx_shift[0];
    end else begin
      miso = tx_shift[WORD_W-1];
    end
  end

  // FIFO push/pop qualification and next occupancy
  always_comb begin
    full      = (fifo_count == FCNT_W'(FIFO_DEPTH));
    empty     = (fifo_count == '0);
    pop_ok    = rd_en && !empty;
    push_ok   = last_bit && (!full || pop_ok);
    ovf_evt   = last_bit && full && !pop_ok;
    rd_ptr_p1 = rd_ptr + PTR_W'(1);
    count_d   = fifo_count;
    if (push_ok && !pop_ok) begin
      count_d = fifo_count + FCNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = fifo_count - FCNT_W'(1);
    end
  end

  // FIFO storage (no reset needed: contents are qualified by the count)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= word_asm;
    end
  end

  // FIFO pointers, occupancy and registered head word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_p1;
      end
      fifo_count <= count_d;
      rd_valid   <= (count_d != '0);
      if (empty) begin
        if (push_ok) begin
          rd_data <= word_asm;
        end
      end else if (pop_ok) begin
        if (fifo_count == FCNT_W'(1)) begin
          if (push_ok) begin
            rd_data <= word_asm;
          end
        end else begin
          rd_data <= mem[rd_ptr_p1];
        end
      end
    end
  end

  // Sticky overflow (set beats clear) and one-cycle abort pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_evt || (overflow && !clr_flags);
      frame_err <= abort;
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: an MSB-first and an LSB-first instance
// share all inputs; expected values are hand-computed constants.
module tb_spi_frame_rx;

  logic       clk;
  logic       rst;
  logic       cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       rd_en;
  logic       clr_flags;

  logic       miso,     l_miso;
  logic       miso_oe,  l_miso_oe;
  logic [7:0] rd_data,  l_rd_data;
  logic       rd_valid, l_rd_valid;
  logic [2:0] fifo_count, l_fifo_count;
  logic       overflow, l_overflow;
  logic       frame_err, l_frame_err;

  int tests;
  int fails;

  spi_frame_rx #(.WORD_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .overflow(overflow),
    .frame_err(frame_err), .clr_flags(clr_flags)
  );

  spi_frame_rx #(.WORD_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(l_miso),
    .miso_oe(l_miso_oe), .tx_data(tx_data), .rd_en(rd_en), .rd_data(l_rd_data),
    .rd_valid(l_rd_valid), .fifo_count(l_fifo_count), .overflow(l_overflow),
    .frame_err(l_frame_err), .clr_flags(clr_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one byte serially, first element = w[7]; optional pop on last bit
  task automatic send_word(input logic [7:0] w, input logic pop_last);
    for (int i = 7; i >= 0; i--) begin
      cs_n  = 1'b0;
      mosi  = w[i];
      rd_en = pop_last && (i == 0);
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] ms;
    logic [7:0] first;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    cs_n      = 1'b1;
    mosi      = 1'b0;
    tx_data   = 8'h00;
    rd_en     = 1'b0;
    clr_flags = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);

    // Single word 1,0,1,0,1,1,0,0
    first = 8'hAC;
    for (int i = 7; i >= 0; i--) begin
      cs_n = 1'b0;
      mosi = first[i];
      if (i == 0) check("valid_before_last", 32'(rd_valid), 32'd0);
      tick();
    end
    check("valid_after_last", 32'(rd_valid), 32'd1);
    check("msb_word", 32'(rd_data), 32'hAC);
    check("lsb_word", 32'(l_rd_data), 32'h35);
    end_frame();
    check("no_frame_err", 32'(frame_err), 32'd0);
    check("count_1", 32'(fifo_count), 32'd1);

    // Second transaction after a gap, no pop
    repeat (5) tick();
    send_word(8'h25, 1'b0);
    end_frame();
    check("count_2", 32'(fifo_count), 32'd2);
    check("lsb_count_2", 32'(l_fifo_count), 32'd2);
    pop_check("pop_ac", 8'hAC);
    check("lsb_second", 32'(l_rd_data), 32'hA4);
    pop_check("pop_25", 8'h25);
    check("empty_after_pops", 32'(rd_valid), 32'd0);
    check("count_0", 32'(fifo_count), 32'd0);

    // Five back-to-back words into a 4-deep FIFO
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("no_ovf_yet", 32'(overflow), 32'd0);
    send_word(8'h55, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    end_frame();
    check("boundary_no_err", 32'(frame_err), 32'd0);
    pop_check("ovf_w0", 8'h11);
    pop_check("ovf_w1", 8'h22);
    pop_check("ovf_w2", 8'h33);
    pop_check("ovf_w3", 8'h44);
    check("ovf_drained", 32'(rd_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with pop on the push edge: both happen, no overflow
    send_word(8'h61, 1'b0);
    send_word(8'h62, 1'b0);
    send_word(8'h63, 1'b0);
    send_word(8'h64, 1'b0);
    send_word(8'h65, 1'b1);
    check("pp_count", 32'(fifo_count), 32'd4);
    check("pp_no_ovf", 32'(overflow), 32'd0);
    end_frame();
    pop_check("pp_w0", 8'h62);
    pop_check("pp_w1", 8'h63);
    pop_check("pp_w2", 8'h64);
    pop_check("pp_w3", 8'h65);
    check("pp_count_0", 32'(fifo_count), 32'd0);

    // Abort after 3 bits
    for (int i = 0; i < 3; i++) begin
      cs_n = 1'b0;
      mosi = 1'b1;
      tick();
    end
    end_frame();
    check("abort_pulse", 32'(frame_err), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    tick();
    check("abort_pulse_end", 32'(frame_err), 32'd0);
    send_word(8'h5A, 1'b0);
    end_frame();
    check("after_abort_word", 32'(rd_data), 32'h5A);
    check("after_abort_count", 32'(fifo_count), 32'd1);
    pop_check("after_abort_pop", 8'h5A);

    // MISO sequence for tx_data 0xC3
    tx_data = 8'hC3;
    tick();
    check("miso_idle", 32'(miso), 32'd0);
    check("miso_oe_idle", 32'(miso_oe), 32'd0);
    ms = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      cs_n = 1'b0;
      mosi = 1'b0;
      #1;
      check($sformatf("miso_b%0d", 7 - i), 32'(miso), 32'(ms[i]));
      check($sformatf("lsb_miso_b%0d", 7 - i), 32'(l_miso), 32'(ms[7 - i]));
      check("miso_oe_act", 32'(miso_oe), 32'd1);
      @(posedge clk);
      #1;
    end
    cs_n = 1'b1;
    #1;
    check("miso_oe_off", 32'(miso_oe), 32'd0);
    tick();
    pop_check("miso_rx_zero", 8'h00);

    // Reset mid-word with a word held in the FIFO
    send_word(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cs_n = 1'b0;
      mosi = 1'b1;
      tick();
    end
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_data", 32'(rd_data), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    rst  = 1'b0;
    tick();
    check("midrst_no_err", 32'(frame_err), 32'd0);
    tick();
    check("midrst_no_err2", 32'(frame_err), 32'd0);
    check("midrst_count2", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
